// File: rtl/bakery_pkg.sv
// Shared types and sizing helpers for the baking-pan station controller.
package bakery_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSeek,
    StSettle,
    StFill,
    StEject,
    StFault
  } pan_fill_state_t;

  // Timer width: $clog2 of the larger of the two tick limits, never below one bit.
  function automatic int unsigned timer_w(input int unsigned settle_ticks,
                                          input int unsigned fill_timeout);
    int unsigned m;
    m = (settle_ticks > fill_timeout) ? settle_ticks : fill_timeout;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pan_fill_timer.sv
// Loadable down-counter gated by the simulation tick; flags zero.
module pan_fill_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      if (load_i) begin
        cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
        cnt_d = cnt_q - Width'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pan_fill_controller.sv
// Baking-pan station sequencer: seek, settle, fill, eject, count.
// Define PAN_FILL_WATCHDOG_EN to enable the FILL watchdog and the FAULT state.
module pan_fill_controller
  import bakery_pkg::*;
#(
  parameter int unsigned SETTLE_TICKS = 4,
  parameter int unsigned FILL_TIMEOUT = 200,
  parameter int unsigned COUNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               run,
  input  logic               clear_fault,
  input  logic               Y_pan,
  input  logic               Y_pan_full,
  input  logic               S_pressure_high,
  output logic               X_pan_conveyor,
  output logic               X_dispenser,
  output logic               busy,
  output logic               fault,
  output logic [COUNT_W-1:0] pans_filled
);

  localparam int unsigned TimerW = timer_w(SETTLE_TICKS, FILL_TIMEOUT);
`ifdef PAN_FILL_WATCHDOG_EN
  localparam bit WdEn = 1'b1;
`else
  localparam bit WdEn = 1'b0;
`endif

  pan_fill_state_t    state_q, state_d;
  logic [COUNT_W-1:0] pans_q, pans_d;
  logic               timer_load, timer_dec, timer_zero;
  logic [TimerW-1:0]  timer_val;

  pan_fill_timer #(
    .Width (TimerW)
  ) u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .dec_i      (timer_dec),
    .zero_o     (timer_zero)
  );

  always_comb begin
    state_d    = state_q;
    pans_d     = pans_q;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    timer_val  = '0;
    case (state_q)
      StIdle: if (run) state_d = StSeek;
      StSeek: begin
        if (!run) begin
          state_d = StIdle;
        end else if (Y_pan) begin
          state_d    = StSettle;
          timer_load = 1'b1;
          timer_val  = TimerW'(SETTLE_TICKS - 1);
        end
      end
      StSettle: begin
        if (!Y_pan) begin
          state_d = StSeek;
        end else if (timer_zero) begin
          if (Y_pan_full) begin
            state_d = StEject;
            pans_d  = pans_q + COUNT_W'(1);
          end else begin
            state_d    = StFill;
            timer_load = WdEn;
            timer_val  = TimerW'(FILL_TIMEOUT - 1);
          end
        end else begin
          timer_dec = 1'b1;
        end
      end
      StFill: begin
        // Full wins over low pressure; run=0 does not abort a fill.
        if (!Y_pan) begin
          state_d = StSeek;
        end else if (Y_pan_full) begin
          state_d = StEject;
          pans_d  = pans_q + COUNT_W'(1);
        end else if (WdEn && timer_zero) begin
          state_d = StFault;
        end else begin
          timer_dec = 1'b1;
        end
      end
      StEject: if (!Y_pan) state_d = run ? StSeek : StIdle;
      StFault: if (clear_fault) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pans_q  <= '0;
    end else if (en) begin
      state_q <= state_d;
      pans_q  <= pans_d;
    end
  end

  assign X_pan_conveyor = (state_q == StSeek) || (state_q == StEject);
  assign X_dispenser    = (state_q == StFill) && S_pressure_high;
  assign busy           = (state_q != StIdle);
  assign fault          = WdEn && (state_q == StFault);
  assign pans_filled    = pans_q;

endmodule

// File: tb/tb_pan_fill_controller.sv
// Bench for pan_fill_controller: vector table, directed corners, random vs reference model.
module tb_pan_fill_controller;

  localparam int SettleTicks = 4;
  localparam int FillTimeout = 20;
  localparam int CountW      = 8;
`ifdef PAN_FILL_WATCHDOG_EN
  localparam bit Wd = 1'b1;
`else
  localparam bit Wd = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0, en = 1'b0, run = 1'b0, clear_fault = 1'b0;
  logic y_pan = 1'b0, y_full = 1'b0, press = 1'b0;
  logic x_conv, x_disp, busy, fault;
  logic [CountW-1:0] pans;

  always #5 clk = ~clk;

  pan_fill_controller #(
    .SETTLE_TICKS (SettleTicks),
    .FILL_TIMEOUT (FillTimeout),
    .COUNT_W      (CountW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .run             (run),
    .clear_fault     (clear_fault),
    .Y_pan           (y_pan),
    .Y_pan_full      (y_full),
    .S_pressure_high (press),
    .X_pan_conveyor  (x_conv),
    .X_dispenser     (x_disp),
    .busy            (busy),
    .fault           (fault),
    .pans_filled     (pans)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: phase name plus ticks spent in the phase.
  localparam int MIdle = 0, MSeek = 1, MSettle = 2, MFill = 3, MEject = 4, MFault = 5;
  int m_st = MIdle, m_dwell = 0, m_pans = 0;

  function automatic void model_reset();
    m_st = MIdle; m_dwell = 0; m_pans = 0;
  endfunction

  function automatic void model_step();
    case (m_st)
      MIdle: if (run) m_st = MSeek;
      MSeek: begin
        if (!run) m_st = MIdle;
        else if (y_pan) begin m_st = MSettle; m_dwell = 0; end
      end
      MSettle: begin
        if (!y_pan) m_st = MSeek;
        else if (m_dwell == SettleTicks - 1) begin
          if (y_full) begin m_st = MEject; m_pans = (m_pans + 1) % (1 << CountW); end
          else begin m_st = MFill; m_dwell = 0; end
        end else m_dwell++;
      end
      MFill: begin
        if (!y_pan) m_st = MSeek;
        else if (y_full) begin m_st = MEject; m_pans = (m_pans + 1) % (1 << CountW); end
        else if (Wd && m_dwell == FillTimeout - 1) m_st = MFault;
        else m_dwell++;
      end
      MEject: if (!y_pan) m_st = run ? MSeek : MIdle;
      MFault: if (clear_fault) m_st = MIdle;
      default: m_st = MIdle;
    endcase
  endfunction

  task automatic chk1(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_exp(input string name, input bit conv, input bit disp, input bit bsy,
                           input bit flt, input int pn);
    chk1({name, ".conv"}, {31'd0, x_conv}, conv);
    chk1({name, ".disp"}, {31'd0, x_disp}, disp);
    chk1({name, ".busy"}, {31'd0, busy}, bsy);
    chk1({name, ".fault"}, {31'd0, fault}, flt);
    chk1({name, ".pans"}, {24'd0, pans}, pn);
  endtask

  task automatic check_model(input string name);
    check_exp(name, (m_st == MSeek) || (m_st == MEject), (m_st == MFill) && press,
              m_st != MIdle, m_st == MFault, m_pans);
  endtask

  task automatic set_in(input bit r, input bit y, input bit f, input bit p, input bit c);
    run = r; y_pan = y; y_full = f; press = p; clear_fault = c;
  endtask

  // One en tick: en high for one clk, low for the next; outputs sampled after both.
  task automatic tick();
    @(negedge clk); en = 1'b1;
    @(posedge clk); #1; model_step();
    @(negedge clk); en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; en = 1'b1;
    @(posedge clk); #1; rst = 1'b0; en = 1'b0;
    model_reset();
  endtask

  // From IDLE with the pan arriving immediately: 1 SEEK tick, 4 SETTLE ticks, then FILL.
  task automatic go_to_fill(input int pn);
    set_in(1, 0, 0, 1, 0); tick();
    set_in(1, 1, 0, 1, 0); repeat (5) tick();
    check_exp("fill_entry", 0, 1, 1, 0, pn);
  endtask

  typedef struct {
    bit run, y, f, p, c;
    bit conv, disp, busy;
    int pans;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input int n, input bit r, input bit y, input bit f, input bit p,
                     input bit c, input bit conv, input bit disp, input bit bsy, input int pn);
    vec_t v;
    v = '{run: r, y: y, f: f, p: p, c: c, conv: conv, disp: disp, busy: bsy, pans: pn};
    repeat (n) vecs.push_back(v);
  endtask

  initial begin
    // Full pan cycle: conveyor 5, settle 4, dispense 8, eject until pan leaves, then stop.
    add(5, 1, 0, 0, 1, 0, 1, 0, 1, 0);
    add(4, 1, 1, 0, 1, 0, 0, 0, 1, 0);
    add(8, 1, 1, 0, 1, 0, 0, 1, 1, 0);
    add(3, 1, 1, 1, 1, 0, 1, 0, 1, 1);
    add(1, 1, 0, 0, 1, 0, 1, 0, 1, 1);
    add(1, 0, 0, 0, 1, 0, 0, 0, 0, 1);

    do_reset();
    check_exp("reset", 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      set_in(vecs[i].run, vecs[i].y, vecs[i].f, vecs[i].p, vecs[i].c);
      tick();
      check_exp($sformatf("vec%0d", i), vecs[i].conv, vecs[i].disp, vecs[i].busy, 0,
                vecs[i].pans);
    end

    // Reset mid-FILL with en high: reset wins, counter cleared.
    go_to_fill(1);
    do_reset();
    check_exp("rst_mid_fill", 0, 0, 0, 0, 0);

    // Low pressure pauses dispensing; full during low pressure still ejects.
    go_to_fill(0);
    set_in(1, 1, 0, 0, 0);
    repeat (3) begin tick(); check_exp("press_low", 0, 0, 1, 0, 0); end
    set_in(1, 1, 0, 1, 0); tick(); check_exp("press_resume", 0, 1, 1, 0, 0);
    set_in(1, 1, 1, 0, 0); tick(); check_exp("full_low_press", 1, 0, 1, 0, 1);
    set_in(1, 0, 0, 1, 0); tick(); check_exp("eject_to_seek", 1, 0, 1, 0, 1);
    set_in(0, 0, 0, 1, 0); tick(); check_exp("seek_to_idle", 0, 0, 0, 0, 1);

    // Pan removed during FILL: back to SEEK, no count.
    go_to_fill(1);
    set_in(1, 0, 0, 1, 0); tick(); check_exp("pan_lost", 1, 0, 1, 0, 1);
    set_in(0, 0, 0, 1, 0); tick(); check_exp("pan_lost_idle", 0, 0, 0, 0, 1);

    // run=0 during FILL lets the fill finish, then stops.
    go_to_fill(1);
    set_in(0, 1, 0, 1, 0); tick(); check_exp("run0_fill", 0, 1, 1, 0, 1);
    set_in(0, 1, 1, 1, 0); tick(); check_exp("run0_eject", 1, 0, 1, 0, 2);
    set_in(0, 0, 0, 1, 0); tick(); check_exp("run0_idle", 0, 0, 0, 0, 2);

    // Watchdog: 20 FILL ticks without full.
    go_to_fill(2);
    if (Wd) begin
      repeat (19) tick();
      check_exp("wd_before", 0, 1, 1, 0, 2);
      tick(); check_exp("wd_fault", 0, 0, 1, 1, 2);
      tick(); check_exp("wd_hold", 0, 0, 1, 1, 2);
      set_in(0, 1, 0, 1, 1); tick(); check_exp("wd_clear", 0, 0, 0, 0, 2);
    end else begin
      repeat (100) tick();
      check_exp("nowd_fill", 0, 1, 1, 0, 2);
      set_in(1, 1, 0, 1, 1); tick(); check_exp("nowd_clear_ignored", 0, 1, 1, 0, 2);
    end
    set_in(0, 0, 0, 1, 0); tick(); tick();
    check_exp("back_idle", 0, 0, 0, 0, 2);

    // Counter wrap: 256 quick pans (full already at end of settle).
    do_reset();
    set_in(1, 0, 0, 1, 0); tick();
    for (int i = 1; i <= 256; i++) begin
      set_in(1, 1, 1, 1, 0); repeat (5) tick();
      chk1($sformatf("wrap_pans%0d", i), {24'd0, pans}, i % 256);
      chk1("wrap_conv", {31'd0, x_conv}, 1);
      set_in(1, 0, 0, 1, 0); tick();
    end

    // Random stimulus against the reference model.
    do_reset();
    set_in(1, 0, 0, 1, 0);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 4) == 0) y_pan = ~y_pan;
      y_full = y_pan && (y_full || ($urandom_range(0, 5) == 0));
      run = ($urandom_range(0, 9) != 0);
      press = ($urandom_range(0, 3) != 0);
      clear_fault = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      else tick();
      check_model($sformatf("rand%0d", i));
      if (x_conv && x_disp) chk1("conv_and_disp", 1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
